// File: rtl/udma_cfg_bridge.sv
// udma_cfg_bridge: APB slave to uDMA cfg-bus bridge.
// One APB access is turned into one request on the cfg bus of the target picked
// by paddr[11:7]. A target index outside 0..N_PERIPHS-1 completes on APB with pslverr.
// The bridge holds one transaction at a time.
// Optional build macro UDMA_CFG_TIMEOUT_EN adds a watchdog. When TIMEOUT_CYCLES REQ
// cycles pass with no ready from the target, the bridge aborts the access with pslverr.
module udma_cfg_bridge #(
  parameter int N_PERIPHS      = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [11:0]                 apb_paddr_i,
  input  logic [31:0]                 apb_pwdata_i,
  input  logic                        apb_pwrite_i,
  input  logic                        apb_psel_i,
  input  logic                        apb_penable_i,
  output logic [31:0]                 apb_prdata_o,
  output logic                        apb_pready_o,
  output logic                        apb_pslverr_o,
  output logic [31:0]                 cfg_data_o,
  output logic [4:0]                  cfg_addr_o,
  output logic                        cfg_rwn_o,
  output logic [N_PERIPHS-1:0]        cfg_valid_o,
  input  logic [N_PERIPHS-1:0][31:0]  cfg_data_i,
  input  logic [N_PERIPHS-1:0]        cfg_ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_e;

  state_e      state_q, state_d;
  logic [4:0]  idx_q;
  logic [4:0]  reg_q;
  logic [31:0] wdata_q;
  logic        rwn_q;
  logic [31:0] rdata_q;

  logic        setup;
  logic        bad_idx;
  logic        access;
  logic        sel_ready;
  logic [31:0] sel_data;
  logic        tmo_hit;

  // paddr[1:0] is ignored: cfg registers are word addressed
  logic unused_paddr;
  assign unused_paddr = ^apb_paddr_i[1:0];

  assign setup   = apb_psel_i & ~apb_penable_i;
  assign access  = apb_psel_i &  apb_penable_i;
  // The compare is widened to 6 bits so that N_PERIPHS=32 also works
  assign bad_idx = {1'b0, apb_paddr_i[11:7]} >= 6'(N_PERIPHS);

  // Select the ready bit and read data of the latched target. A match happens only for legal indices.
  always_comb begin
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_PERIPHS; i++) begin
      if (idx_q == 5'(i)) begin
        sel_ready = cfg_ready_i[i];
        sel_data  = cfg_data_i[i];
      end
    end
  end

`ifdef UDMA_CFG_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_q;

  // Count REQ cycles. The counter stays at 0 outside REQ, so each access starts from 0.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)               tmo_q <= '0;
    else if (state_q != S_REQ) tmo_q <= '0;
    else                       tmo_q <= tmo_q + 1'b1;
  end

  // This is true in the REQ cycle that is number TIMEOUT_CYCLES. Ready in the same cycle still wins.
  assign tmo_hit = (tmo_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign tmo_hit        = 1'b0;
`endif

  // FSM state register. Reset is asynchronous, so a request that is in flight is dropped at once.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (setup) state_d = bad_idx ? S_ERR : S_REQ;
      S_REQ: begin
        if (sel_ready)    state_d = S_DONE;
        else if (tmo_hit) state_d = S_ERR;
      end
      // The result is delivered in one access cycle, or dropped if psel was released
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the request fields in the setup phase. These registers drive the cfg bus.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idx_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rwn_q   <= 1'b0;
    end else if (state_q == S_IDLE && setup) begin
      idx_q   <= apb_paddr_i[11:7];
      reg_q   <= apb_paddr_i[6:2];
      wdata_q <= apb_pwdata_i;
      rwn_q   <= ~apb_pwrite_i;
    end
  end

  // Capture target data on the ready cycle. A write stores 0, so old read data never returns.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                         rdata_q <= '0;
    else if (state_q == S_REQ && sel_ready) rdata_q <= rwn_q ? sel_data : 32'h0;
  end

  // One-hot strobe. It is high only in REQ, so it drops on the same edge that sees ready or timeout.
  always_comb begin
    cfg_valid_o = '0;
    for (int i = 0; i < N_PERIPHS; i++)
      cfg_valid_o[i] = (state_q == S_REQ) && (idx_q == 5'(i));
  end

  assign cfg_addr_o = reg_q;
  assign cfg_data_o = wdata_q;
  assign cfg_rwn_o  = rwn_q;

  // APB completion. It is driven only during an access cycle in DONE or ERR. prdata is 0 except on a good completion.
  always_comb begin
    apb_pready_o  = 1'b0;
    apb_pslverr_o = 1'b0;
    apb_prdata_o  = '0;
    if (access && state_q == S_DONE) begin
      apb_pready_o = 1'b1;
      apb_prdata_o = rdata_q;
    end else if (access && state_q == S_ERR) begin
      apb_pready_o  = 1'b1;
      apb_pslverr_o = 1'b1;
    end
  end

endmodule
